// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: phase and approach
// encodings, lamp patterns and the density-level decode.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_ALL_RED   = 2'd0,
        PH_GREEN     = 2'd1,
        PH_YELLOW    = 2'd2,
        PH_PRE_GREEN = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        APP_A = 2'd0,
        APP_B = 2'd1,
        APP_C = 2'd2,
        APP_D = 2'd3
    } approach_t;

    // Per-approach lamp field is {red, yellow, green}.
    localparam logic [2:0]  LAMP_R        = 3'b100;
    localparam logic [2:0]  LAMP_Y        = 3'b010;
    localparam logic [2:0]  LAMP_G        = 3'b001;
    localparam logic [11:0] ALL_RED_LIGHT = {4{LAMP_R}};

    // Highest set sensor of one approach wins; no sensor means level 0.
    function automatic logic [1:0] density_level(input logic [2:0] s);
        if (s[2])      return 2'd3;
        else if (s[1]) return 2'd2;
        else if (s[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    // Only the granted approach may leave red.
    function automatic logic [11:0] lamp_vector(input phase_t ph, input logic [1:0] g);
        logic [11:0] v;
        v = ALL_RED_LIGHT;
        case (ph)
            PH_GREEN, PH_PRE_GREEN: v[3*int'(g) +: 3] = LAMP_G;
            PH_YELLOW:              v[3*int'(g) +: 3] = LAMP_Y;
            default:                ;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Chooses the next approach to serve: emergency requests first (lowest index),
// otherwise the first approach after last_grant with nonzero density.
module rr_picker
    import traffic_pkg::*;
(
    input  logic [3:0][1:0] lvl,
    input  logic [1:0]      last_grant,
    input  logic [3:0]      ss,
    output logic [1:0]      next_grant,
    output logic            valid,
    output logic            from_ss
);

    logic [1:0] idx;

    always_comb begin
        next_grant = last_grant;
        valid      = 1'b0;
        from_ss    = 1'b0;
        idx        = last_grant;
        if (|ss) begin
            valid   = 1'b1;
            from_ss = 1'b1;
            for (int i = 3; i >= 0; i--) begin
                if (ss[i]) next_grant = 2'(i);
            end
        end else begin
            // Walk backwards so the nearest candidate overwrites the farther ones;
            // k=4 wraps to last_grant itself, which is therefore considered last.
            for (int k = 4; k >= 1; k--) begin
                idx = last_grant + 2'(k);
                if (lvl[idx] != 2'd0) begin
                    next_grant = idx;
                    valid      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-approach green-time sequencer: round-robin with density-scaled green,
// gap-out after minimum green, and emergency preemption.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_BASE = 4,
    parameter int GREEN_STEP = 4,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1,
    parameter int TW         = 6
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        tick,
    input  logic [11:0] dens,
    input  logic [3:0]  ss,
    output logic [11:0] light,
    output logic [1:0]  grant,
    output logic [1:0]  phase,
    output logic [1:0]  level,
    output logic        preempt_on
);

    phase_t          phase_q;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   elapsed;
    logic [TW-1:0]   elapsed_now;
    logic [1:0]      grant_q;
    logic [1:0]      level_q;
    logic            preempt_q;
    logic            pre_done;
    logic [11:0]     light_q;
    logic [3:0][1:0] lvl;
    logic [1:0]      pick_grant;
    logic            pick_valid;
    logic            pick_ss;
    logic            timer_done;
    logic            gap_out;
    logic            ar_ready;

    function automatic logic [TW-1:0] green_time(input logic [1:0] l);
        case (l)
            2'd2:    return TW'(GREEN_BASE + GREEN_STEP);
            2'd3:    return TW'(GREEN_BASE + 2 * GREEN_STEP);
            default: return TW'(GREEN_BASE);
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) lvl[i] = density_level(dens[3*i +: 3]);
    end

    rr_picker u_picker (
        .lvl        (lvl),
        .last_grant (grant_q),
        .ss         (ss),
        .next_grant (pick_grant),
        .valid      (pick_valid),
        .from_ss    (pick_ss)
    );

    assign timer_done  = tick && (timer == TW'(1));
    // Counting the current tick lets gap-out land on the same edge as a
    // level-1 timer expiry, so the two collapse into one yellow.
    assign elapsed_now = elapsed + TW'(tick);
    assign gap_out     = (lvl[grant_q] == 2'd0) && (elapsed_now >= TW'(GREEN_BASE));
    // A zero timer in ALL_RED means resting: rescan on every clock.
    assign ar_ready    = (timer == '0) || timer_done;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            phase_q   <= PH_ALL_RED;
            timer     <= TW'(ALLRED_T);
            elapsed   <= '0;
            grant_q   <= APP_D;
            level_q   <= 2'd0;
            preempt_q <= 1'b0;
            pre_done  <= 1'b0;
            light_q   <= ALL_RED_LIGHT;
        end else begin
            case (phase_q)
                PH_ALL_RED: begin
                    if (ar_ready) begin
                        if (pick_valid) begin
                            grant_q  <= pick_grant;
                            level_q  <= lvl[pick_grant];
                            elapsed  <= '0;
                            pre_done <= 1'b0;
                            if (pick_ss) begin
                                phase_q   <= PH_PRE_GREEN;
                                timer     <= '0;
                                preempt_q <= 1'b1;
                                light_q   <= lamp_vector(PH_PRE_GREEN, pick_grant);
                            end else begin
                                phase_q   <= PH_GREEN;
                                timer     <= green_time(lvl[pick_grant]);
                                preempt_q <= 1'b0;
                                light_q   <= lamp_vector(PH_GREEN, pick_grant);
                            end
                        end else begin
                            timer     <= '0;
                            preempt_q <= 1'b0;
                        end
                    end else if (tick) begin
                        timer <= timer - TW'(1);
                    end
                end

                PH_GREEN: begin
                    if (ss[grant_q]) begin
                        // Emergency on the served approach keeps its green, no gap.
                        phase_q   <= PH_PRE_GREEN;
                        timer     <= '0;
                        preempt_q <= 1'b1;
                        light_q   <= lamp_vector(PH_PRE_GREEN, grant_q);
                    end else if (|ss) begin
                        phase_q   <= PH_YELLOW;
                        timer     <= TW'(YELLOW_T);
                        preempt_q <= 1'b1;
                        light_q   <= lamp_vector(PH_YELLOW, grant_q);
                    end else if (timer_done || gap_out) begin
                        phase_q <= PH_YELLOW;
                        timer   <= TW'(YELLOW_T);
                        light_q <= lamp_vector(PH_YELLOW, grant_q);
                    end else if (tick) begin
                        timer   <= timer - TW'(1);
                        elapsed <= elapsed_now;
                    end
                end

                PH_YELLOW: begin
                    if (timer_done) begin
                        phase_q <= PH_ALL_RED;
                        timer   <= TW'(ALLRED_T);
                        level_q <= 2'd0;
                        light_q <= ALL_RED_LIGHT;
                        if (pre_done) begin
                            preempt_q <= 1'b0;
                            pre_done  <= 1'b0;
                        end
                    end else if (tick) begin
                        timer <= timer - TW'(1);
                    end
                end

                PH_PRE_GREEN: begin
                    if (!ss[grant_q]) begin
                        phase_q  <= PH_YELLOW;
                        timer    <= TW'(YELLOW_T);
                        pre_done <= 1'b1;
                        light_q  <= lamp_vector(PH_YELLOW, grant_q);
                    end
                end

                default: begin
                    phase_q <= PH_ALL_RED;
                    timer   <= TW'(ALLRED_T);
                    light_q <= ALL_RED_LIGHT;
                end
            endcase
        end
    end

    assign light      = light_q;
    assign grant      = grant_q;
    assign phase      = phase_q;
    assign level      = level_q;
    assign preempt_on = preempt_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural model of the phase rules.
module tb_traffic_phase_scheduler;

    logic        clock;
    logic        clear;
    logic        tick;
    logic [11:0] dens;
    logic [3:0]  ss;
    logic [11:0] light;
    logic [1:0]  grant;
    logic [1:0]  phase;
    logic [1:0]  level;
    logic        preempt_on;

    int n_cmp = 0;
    int n_err = 0;

    logic [18:0] exp_q[$];

    int green_ticks[4];
    int yellow_ticks;

    // Reference model state, in ticks and plain integers.
    int m_phase, m_grant, m_level, m_remain, m_served;
    bit m_pre, m_after_pre, m_rest;

    traffic_phase_scheduler dut (
        .clock      (clock),
        .clear      (clear),
        .tick       (tick),
        .dens       (dens),
        .ss         (ss),
        .light      (light),
        .grant      (grant),
        .phase      (phase),
        .level      (level),
        .preempt_on (preempt_on)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int dl(input logic [2:0] s);
        if (s[2]) return 3;
        if (s[1]) return 2;
        if (s[0]) return 1;
        return 0;
    endfunction

    function automatic logic [11:0] exp_light(input int ph, input int g);
        logic [11:0] v;
        for (int i = 0; i < 4; i++) begin
            if (i == g && (ph == 1 || ph == 3)) v[3*i +: 3] = 3'b001;
            else if (i == g && ph == 2)         v[3*i +: 3] = 3'b010;
            else                                v[3*i +: 3] = 3'b100;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_remain = 1; m_grant = 3; m_level = 0;
        m_served = 0; m_pre = 0; m_after_pre = 0; m_rest = 0;
    endtask

    task automatic model_step(input logic [11:0] d, input logic [3:0] s, input bit t);
        int lv[4];
        int low;
        bit found;
        for (int i = 0; i < 4; i++) lv[i] = dl(d[3*i +: 3]);
        case (m_phase)
            0: begin
                if (m_rest || (t && m_remain == 1)) begin
                    if (s != 4'd0) begin
                        low = 3;
                        for (int i = 3; i >= 0; i--) if (s[i]) low = i;
                        m_phase = 3; m_grant = low; m_level = lv[low];
                        m_pre = 1; m_after_pre = 0; m_rest = 0; m_served = 0;
                    end else begin
                        found = 0;
                        for (int k = 1; k <= 4; k++) begin
                            if (!found && lv[(m_grant + k) % 4] > 0) begin
                                found = 1;
                                m_grant = (m_grant + k) % 4;
                            end
                        end
                        m_pre = 0;
                        if (found) begin
                            m_phase = 1; m_level = lv[m_grant];
                            m_remain = 4 + 4 * (m_level - 1);
                            m_served = 0; m_rest = 0; m_after_pre = 0;
                        end else begin
                            m_rest = 1;
                        end
                    end
                end else if (t) begin
                    m_remain--;
                end
            end
            1: begin
                if (s[m_grant]) begin
                    m_phase = 3; m_pre = 1;
                end else if (s != 4'd0) begin
                    m_phase = 2; m_remain = 3; m_pre = 1;
                end else if ((t && m_remain == 1) ||
                             (lv[m_grant] == 0 && m_served + int'(t) >= 4)) begin
                    m_phase = 2; m_remain = 3;
                end else if (t) begin
                    m_remain--; m_served++;
                end
            end
            2: begin
                if (t && m_remain == 1) begin
                    m_phase = 0; m_remain = 1; m_level = 0;
                    if (m_after_pre) begin
                        m_pre = 0; m_after_pre = 0;
                    end
                end else if (t) begin
                    m_remain--;
                end
            end
            default: begin
                if (!s[m_grant]) begin
                    m_phase = 2; m_remain = 3; m_after_pre = 1;
                end
            end
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit t);
        logic [18:0] e;
        @(negedge clock);
        if (t) begin
            if (phase == 2'd1) green_ticks[grant]++;
            if (phase == 2'd2) yellow_ticks++;
        end
        tick = t;
        model_step(dens, ss, t);
        exp_q.push_back({exp_light(m_phase, m_grant), 2'(m_phase), 2'(m_grant),
                         2'(m_level), m_pre});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check("light", 32'(light), 32'(e[18:7]));
        check("phase", 32'(phase), 32'(e[6:5]));
        check("grant", 32'(grant), 32'(e[4:3]));
        check("preempt_on", 32'(preempt_on), 32'(e[0]));
        if (e[6:5] == 2'd1) check("level", 32'(level), 32'(e[2:1]));
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            cycle(1'b0);
            cycle(1'b1);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) green_ticks[i] = 0;
        yellow_ticks = 0;
    endtask

    // Asserts clear between clock edges and checks the outputs drop at once.
    task automatic apply_reset();
        @(negedge clock);
        tick = 1'b0;
        ss   = 4'd0;
        #2 clear = 1'b0;
        #1;
        check("rst_light", 32'(light), 32'h924);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_grant", 32'(grant), 32'd3);
        check("rst_preempt", 32'(preempt_on), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        model_reset();
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        clear_counts();
    endtask

    // ---------------- scenarios ----------------
    initial begin
        clear = 1'b0;
        tick  = 1'b0;
        dens  = 12'd0;
        ss    = 4'd0;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;

        // Idle: nothing requested, stays all red.
        run_ticks(20);
        check("idle_light", 32'(light), 32'h924);
        check("idle_phase", 32'(phase), 32'd0);
        check("idle_preempt", 32'(preempt_on), 32'd0);

        // Round robin A(level1), B(level2), C(level3).
        apply_reset();
        dens = 12'b000_100_010_001;
        run_ticks(37);
        check("seq_green_a", 32'(green_ticks[0]), 32'd4);
        check("seq_green_b", 32'(green_ticks[1]), 32'd8);
        check("seq_green_c", 32'(green_ticks[2]), 32'd12);
        check("seq_yellow", 32'(yellow_ticks), 32'd9);
        check("seq_again_phase", 32'(phase), 32'd1);
        check("seq_again_grant", 32'(grant), 32'd0);

        // Gap-out: B level 3 drops out after 2 green ticks, A waiting.
        apply_reset();
        dens = 12'b000_000_100_000;
        run_ticks(3);
        dens = 12'b000_000_000_001;
        run_ticks(6);
        check("gap_green_b", 32'(green_ticks[1]), 32'd4);
        check("gap_next_phase", 32'(phase), 32'd1);
        check("gap_next_grant", 32'(grant), 32'd0);

        // Preemption of A's green by C.
        apply_reset();
        dens = 12'b000_000_000_100;
        run_ticks(3);
        ss = 4'b0100;
        cycle(1'b0);
        check("pre_yellow_phase", 32'(phase), 32'd2);
        check("pre_yellow_lamp_a", 32'(light[2:0]), 32'b010);
        check("pre_yellow_flag", 32'(preempt_on), 32'd1);
        run_ticks(4);
        check("pre_c_phase", 32'(phase), 32'd3);
        check("pre_c_grant", 32'(grant), 32'd2);
        check("pre_c_light", 32'(light), 32'h864);
        check("pre_c_flag", 32'(preempt_on), 32'd1);
        run_ticks(5);
        check("pre_c_hold", 32'(phase), 32'd3);
        ss = 4'b0000;
        cycle(1'b0);
        check("pre_c_yellow", 32'(phase), 32'd2);
        run_ticks(4);
        check("pre_resume_phase", 32'(phase), 32'd1);
        check("pre_resume_grant", 32'(grant), 32'd0);
        check("pre_resume_flag", 32'(preempt_on), 32'd0);

        // Contention: B and D request together while resting in all red.
        apply_reset();
        dens = 12'd0;
        run_ticks(1);
        ss = 4'b1010;
        cycle(1'b0);
        check("cont_grant_b", 32'(grant), 32'd1);
        check("cont_phase_b", 32'(phase), 32'd3);
        run_ticks(3);
        check("cont_hold_b", 32'(grant), 32'd1);
        ss = 4'b1000;
        cycle(1'b0);
        check("cont_b_yellow", 32'(phase), 32'd2);
        run_ticks(4);
        check("cont_grant_d", 32'(grant), 32'd3);
        check("cont_phase_d", 32'(phase), 32'd3);
        check("cont_flag_d", 32'(preempt_on), 32'd1);
        ss = 4'b0000;
        run_ticks(5);

        // Async clear during yellow; A served first afterwards.
        apply_reset();
        dens = 12'b000_000_000_001;
        run_ticks(5);
        cycle(1'b0);
        check("ar_in_yellow", 32'(phase), 32'd2);
        apply_reset();
        run_ticks(1);
        check("ar_first_grant", 32'(grant), 32'd0);
        check("ar_first_phase", 32'(phase), 32'd1);

        // Random traffic against the model.
        apply_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0) dens = 12'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 1) == 0) ss = 4'd0;
                else ss = 4'(1 << $urandom_range(0, 3)) | ($urandom_range(0, 3) == 0 ? 4'($urandom) : 4'd0);
            end
            cycle(bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
